// File: rtl/vcve2_pkg.sv
// Shared types for the vcve2 fetch path: prefetch queue entry and request FSM states.
package vcve2_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        err;
    } prefetch_entry_t;

    typedef enum logic [0:0] {
        PF_IDLE = 1'b0,
        PF_REQ  = 1'b1
    } pf_state_e;

endpackage

// File: rtl/vcve2_prefetch_fifo.sv
// Circular FIFO of prefetch entries with push, pop, flush and occupancy.
module vcve2_prefetch_fifo
    import vcve2_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push,
    input  prefetch_entry_t              wdata,
    input  logic                         pop,
    input  logic                         flush,
    output prefetch_entry_t              head,
    output logic                         empty,
    output logic [$clog2(Depth+1)-1:0]   level
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned LvlW = $clog2(Depth + 1);

    prefetch_entry_t mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [LvlW-1:0] count;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == LvlW'(Depth));
    assign empty   = (count == '0);
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign level   = count;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PtrW'(1);
            count <= count + LvlW'(push_ok) - LvlW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush) mem[wr_ptr] <= wdata;
    end

    overflow_a:  assert property (@(posedge clk_i) disable iff (rst_i) !(push && full && !pop));
    underflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty));

endmodule

// File: rtl/vcve2_prefetch_queue.sv
// Instruction prefetch queue: credit-limited OBI request FSM, branch flush with
// in-flight discard, error stop, and a buffering FIFO.
module vcve2_prefetch_queue
    import vcve2_pkg::*;
#(
    parameter int unsigned Depth          = 4,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    input  logic                         branch_i,
    input  logic [31:0]                  branch_addr_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic [31:0]                  rdata_o,
    output logic [31:0]                  addr_o,
    output logic                         err_o,
    output logic                         instr_req_o,
    output logic [31:0]                  instr_addr_o,
    input  logic                         instr_gnt_i,
    input  logic                         instr_rvalid_i,
    input  logic [31:0]                  instr_rdata_i,
    input  logic                         instr_err_i,
    output logic                         busy_o,
    output logic [$clog2(Depth+1)-1:0]   level_o
);

    localparam int unsigned LvlW = $clog2(Depth + 1);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned SumW = LvlW + CntW + 1;

    pf_state_e       state_q, state_d;
    logic [31:0]     fetch_addr_q, fetch_addr_d;
    logic [31:0]     resp_addr_q, resp_addr_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] discard_q, discard_d;
    logic            addr_valid_q, addr_valid_d;
    logic            err_stop_q, err_stop_d;
    logic            first_q, first_d;
    logic            branch_off_q, branch_off_d;
    logic            stale_q, stale_d;
    logic            req_q, busy_q;

    logic            gnt_hs, rsp, drop, push, pop, issue;
    logic [SumW-1:0] level_next, credit_used;
    logic [31:0]     branch_word;
    prefetch_entry_t push_entry, head;
    logic            fifo_empty;
    logic [LvlW-1:0] fifo_level;
    logic            unused_addr_bit;

    assign unused_addr_bit = branch_addr_i[0];
    assign branch_word     = {branch_addr_i[31:2], 2'b00};

    assign valid_o      = ~fifo_empty & ~branch_i;
    assign rdata_o      = head.rdata;
    assign addr_o       = head.addr;
    assign err_o        = head.err;
    assign level_o      = fifo_level;
    assign instr_req_o  = req_q;
    assign instr_addr_o = req_addr_q;
    assign busy_o       = busy_q;

    // Next-state, counters and address tracking; credits use post-update values.
    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        resp_addr_d   = resp_addr_q;
        req_addr_d    = req_addr_q;
        addr_valid_d  = addr_valid_q | branch_i;
        err_stop_d    = err_stop_q;
        first_d       = first_q;
        branch_off_d  = branch_off_q;
        stale_d       = stale_q;

        gnt_hs = req_q & instr_gnt_i;
        rsp    = instr_rvalid_i & (outstanding_q != '0);
        drop   = rsp & (discard_q != '0);
        push   = rsp & ~drop & ~branch_i;
        pop    = valid_o & ready_i;

        push_entry.rdata = instr_rdata_i;
        push_entry.addr  = first_q ? {resp_addr_q[31:2], branch_off_q, 1'b0} : resp_addr_q;
        push_entry.err   = instr_err_i;

        outstanding_d = outstanding_q + CntW'(gnt_hs) - CntW'(rsp);
        discard_d     = discard_q + CntW'(gnt_hs & stale_q) - CntW'(drop);

        if (gnt_hs) begin
            stale_d = 1'b0;
            if (!stale_q) fetch_addr_d = fetch_addr_q + 32'd4;
        end
        if (push) begin
            resp_addr_d = resp_addr_q + 32'd4;
            first_d     = 1'b0;
            if (instr_err_i) err_stop_d = 1'b1;
        end
        if (branch_i) begin
            fetch_addr_d = branch_word;
            resp_addr_d  = branch_word;
            discard_d    = outstanding_d;
            err_stop_d   = 1'b0;
            first_d      = 1'b1;
            branch_off_d = branch_addr_i[1];
            if (state_q == PF_REQ && !gnt_hs) stale_d = 1'b1;
        end

        level_next  = branch_i ? '0 : SumW'(fifo_level) + SumW'(push) - SumW'(pop);
        credit_used = level_next + SumW'(outstanding_d) - SumW'(discard_d);
        issue = addr_valid_q & req_i & ~err_stop_d & ~branch_i
              & (outstanding_d < CntW'(MaxOutstanding))
              & (credit_used < SumW'(Depth));

        case (state_q)
            PF_IDLE: if (issue) state_d = PF_REQ;
            PF_REQ:  if (gnt_hs && !issue) state_d = PF_IDLE;
            default: state_d = PF_IDLE;
        endcase

        if (state_d == PF_REQ && (state_q == PF_IDLE || gnt_hs)) req_addr_d = fetch_addr_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= PF_IDLE;
            fetch_addr_q  <= '0;
            resp_addr_q   <= '0;
            req_addr_q    <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            addr_valid_q  <= 1'b0;
            err_stop_q    <= 1'b0;
            first_q       <= 1'b0;
            branch_off_q  <= 1'b0;
            stale_q       <= 1'b0;
            req_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            resp_addr_q   <= resp_addr_d;
            req_addr_q    <= req_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            addr_valid_q  <= addr_valid_d;
            err_stop_q    <= err_stop_d;
            first_q       <= first_d;
            branch_off_q  <= branch_off_d;
            stale_q       <= stale_d;
            req_q         <= (state_d == PF_REQ);
            busy_q        <= (state_d == PF_REQ) | (outstanding_d != '0);
        end
    end

    vcve2_prefetch_fifo #(.Depth(Depth)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .flush (branch_i),
        .head  (head),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_vcve2_prefetch_queue.sv
// Bench for vcve2_prefetch_queue: memory responder, scoreboard of expected head entries,
// a phase table plus hand-written branch/error/backpressure sequences.
module tb_vcve2_prefetch_queue;
    import vcve2_pkg::*;

    localparam int Depth  = 4;
    localparam int MaxOut = 2;

    logic        clk_i = 1'b0;
    logic        rst_i, req_i, branch_i, ready_i;
    logic [31:0] branch_addr_i;
    logic        valid_o, err_o, instr_req_o, busy_o;
    logic [31:0] rdata_o, addr_o, instr_addr_o;
    logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] instr_rdata_i;
    logic [2:0]  level_o;

    always #5 clk_i = ~clk_i;

    vcve2_prefetch_queue #(.Depth(Depth), .MaxOutstanding(MaxOut)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .ready_i(ready_i), .valid_o(valid_o),
        .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o), .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .instr_err_i(instr_err_i), .busy_o(busy_o), .level_o(level_o)
    );

    typedef struct {
        logic [31:0] target;
        int          ncyc;
        logic        ready;
        logic        gnt;
        logic        rsp;
        int          exp_level;
        logic        exp_req;
        logic        exp_busy;
        int          min_pops;
    } vec_t;

    int              errors = 0;
    int              checks = 0;
    int              pops, err_pops;
    logic            gnt_en, rsp_en;
    logic [31:0]     err_addr;
    logic [31:0]     mem_q[$];
    logic [31:0]     gnt_log[$];
    prefetch_entry_t exp_q[$];
    vec_t            vec[6];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_true(input string name, input logic cond);
        checks++;
        if (cond !== 1'b1) begin
            errors++;
            $display("FAIL %s: condition false (t=%0t)", name, $time);
        end
    endtask

    // Expected head stream after a branch: first entry keeps the halfword offset.
    task automatic fill_exp(input logic [31:0] target);
        prefetch_entry_t e;
        logic [31:0] w;
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            w       = {target[31:2], 2'b00} + 32'(4 * i);
            e.rdata = mem_data(w);
            e.addr  = (i == 0) ? {w[31:2], target[1], 1'b0} : w;
            e.err   = (w == err_addr);
            exp_q.push_back(e);
        end
    endtask

    // One clock: drive memory side at negedge, observe handshakes, wait next negedge.
    task automatic cycle();
        prefetch_entry_t e;
        instr_gnt_i = gnt_en;
        if (rsp_en && mem_q.size() != 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_data(mem_q[0]);
            instr_err_i    = (mem_q[0] == err_addr);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
            instr_err_i    = 1'b0;
        end
        #1;
        if (valid_o && ready_i) begin
            pops++;
            if (err_o) err_pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got addr %h, nothing expected", addr_o);
            end else begin
                e = exp_q.pop_front();
                check("pop_addr", addr_o, e.addr);
                check("pop_rdata", rdata_o, e.rdata);
                check("pop_err", 32'(err_o), 32'(e.err));
            end
        end
        if (instr_rvalid_i) void'(mem_q.pop_front());
        if (instr_req_o && instr_gnt_i) begin
            check("req_align", 32'(instr_addr_o[1:0]), 32'h0);
            mem_q.push_back(instr_addr_o);
            gnt_log.push_back(instr_addr_o);
            check_true("outstanding_le_max", mem_q.size() <= MaxOut);
        end
        check_true("level_le_depth", int'(level_o) <= Depth);
        @(negedge clk_i);
    endtask

    task automatic branch(input logic [31:0] target);
        gnt_log.delete();
        fill_exp(target);
        branch_i      = 1'b1;
        branch_addr_i = target;
        cycle();
        branch_i      = 1'b0;
        #1;
        check("flush_level", 32'(level_o), 32'h0);
        check("flush_valid", 32'(valid_o), 32'h0);
    endtask

    task automatic drain();
        req_i  = 1'b0;
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        repeat (8) cycle();
        req_i  = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{32'h100, 20, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 15};
        vec[1] = '{32'h300, 20, 1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0, 0};
        vec[2] = '{32'h302, 12, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 5};
        vec[3] = '{32'h400, 10, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b1, 0};
        vec[4] = '{32'h500, 15, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 0};
        vec[5] = '{32'h602, 20, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 10};

        rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0; ready_i = 1'b0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
        gnt_en = 1'b0; rsp_en = 1'b0; err_addr = 32'h1; pops = 0; err_pops = 0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_instr_req", 32'(instr_req_o), 32'h0);
        check("rst_instr_addr", instr_addr_o, 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_level", 32'(level_o), 32'h0);

        // No fetch address yet: requests must not start before the first branch.
        req_i = 1'b1;
        repeat (5) cycle();
        check("no_req_before_branch", 32'(instr_req_o), 32'h0);

        for (int i = 0; i < 6; i++) begin
            ready_i = vec[i].ready;
            gnt_en  = vec[i].gnt;
            rsp_en  = vec[i].rsp;
            pops    = 0;
            branch(vec[i].target);
            repeat (vec[i].ncyc) cycle();
            check("vec_level", 32'(level_o), 32'(vec[i].exp_level));
            check("vec_req", 32'(instr_req_o), 32'(vec[i].exp_req));
            check("vec_busy", 32'(busy_o), 32'(vec[i].exp_busy));
            check_true("vec_min_pops", pops >= vec[i].min_pops);
        end

        // Ungranted request across a branch keeps its address; its response is dropped.
        drain();
        ready_i = 1'b1; gnt_en = 1'b0; rsp_en = 1'b1; pops = 0;
        branch(32'h108);
        for (int i = 0; i < 10 && !instr_req_o; i++) cycle();
        check("stall_req_up", 32'(instr_req_o), 32'h1);
        check("stall_req_addr", instr_addr_o, 32'h108);
        branch(32'h400);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("held_req", 32'(instr_req_o), 32'h1);
            check("held_addr", instr_addr_o, 32'h108);
        end
        gnt_en = 1'b1;
        repeat (15) cycle();
        check_true("gnt_log_len", gnt_log.size() >= 2);
        if (gnt_log.size() >= 2) begin
            check("first_gnt", gnt_log[0], 32'h108);
            check("second_gnt", gnt_log[1], 32'h400);
        end
        check_true("stall_pops", pops > 0);

        // Bus error stops fetching until the next branch.
        drain();
        err_addr = 32'h10C; ready_i = 1'b1; err_pops = 0; pops = 0;
        branch(32'h100);
        repeat (25) cycle();
        check("err_pop_count", 32'(err_pops), 32'h1);
        check("err_req_low", 32'(instr_req_o), 32'h0);
        check("err_busy_low", 32'(busy_o), 32'h0);
        check_true("err_gnt_bound", gnt_log.size() > 0 && gnt_log[$] >= 32'h10C && gnt_log[$] <= 32'h114);
        pops = 0;
        branch(32'h500);
        repeat (10) cycle();
        check_true("resume_gnt", gnt_log.size() > 0);
        if (gnt_log.size() > 0) check("resume_addr", gnt_log[0], 32'h500);
        check_true("resume_pops", pops > 0);

        // Full FIFO then resume consumption with grants flowing.
        drain();
        ready_i = 1'b0;
        branch(32'h700);
        repeat (15) cycle();
        check("full_level", 32'(level_o), 32'h4);
        check("full_req_low", 32'(instr_req_o), 32'h0);
        ready_i = 1'b1; pops = 0;
        repeat (10) cycle();
        check_true("full_resume_pops", pops >= 8);
        check("full_resume_req", 32'(instr_req_o), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
